// File: rtl/receptor_arduino_if.sv
// Link between the Arduino serial line and the game core's keypad inputs.
// The Arduino side (master) drives rx and observes the decoded outputs.
// The receiver (slave) drives the command pulses and the debug signals.
interface receptor_arduino_if;
  logic       rx;
  logic       right_arrow_pressed;
  logic       left_arrow_pressed;
  logic       enter_pressed;
  logic       cmd_invalido;
  logic       erro_quadro;
  logic [7:0] ultimo_cmd;
  logic [2:0] db_estado;

  modport master (
    output rx,
    input  right_arrow_pressed,
    input  left_arrow_pressed,
    input  enter_pressed,
    input  cmd_invalido,
    input  erro_quadro,
    input  ultimo_cmd,
    input  db_estado
  );

  modport slave (
    input  rx,
    output right_arrow_pressed,
    output left_arrow_pressed,
    output enter_pressed,
    output cmd_invalido,
    output erro_quadro,
    output ultimo_cmd,
    output db_estado
  );
endinterface

// File: rtl/receptor_arduino.sv
// Serial receiver for the Arduino keypad/LCD link.
// It deserialises UART frames from rx and turns command bytes into one-cycle pulses:
// 'R' gives right arrow, 'L' gives left arrow and 'E' gives enter.
// Optional macro RX_PARITY_EN: when defined, frames are 8E1 and a PARIDADE state checks even
// parity. When it is undefined, frames are 8N1.
module receptor_arduino #(
  parameter int unsigned CLOCK_FREQ  = 50000000,
  parameter int unsigned BAUD        = 9600,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic               clock,
  input logic               reset,
  receptor_arduino_if.slave bus
);

  localparam int unsigned CLKS_PER_BIT = CLOCK_FREQ / BAUD;
  localparam int unsigned TIMER_W      = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TIMER_W-1:0] LAST_TICK = TIMER_W'(CLKS_PER_BIT - 1);
  localparam logic [TIMER_W-1:0] HALF_TICK = TIMER_W'(CLKS_PER_BIT / 2 - 1);

  localparam logic [7:0] CMD_RIGHT = 8'h52;
  localparam logic [7:0] CMD_LEFT  = 8'h4C;
  localparam logic [7:0] CMD_ENTER = 8'h45;

  typedef enum logic [2:0] {
    StOcioso     = 3'd0,
    StInicio     = 3'd1,
    StDados      = 3'd2,
`ifdef RX_PARITY_EN
    StParidade   = 3'd3,
`endif
    StParada     = 3'd4,
    StDecodifica = 3'd5,
    StEspera     = 3'd6
  } state_e;

  state_e               state_q, state_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [7:0]           shift_q, shift_d;
  logic [7:0]           ultimo_q, ultimo_d;
  logic                 right_q, right_d;
  logic                 left_q, left_d;
  logic                 enter_q, enter_d;
  logic                 invalido_q, invalido_d;
  logic                 erro_q, erro_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                 rxs;
  logic                 tick;

  // Synchroniser for the asynchronous rx line; it resets to the idle level.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.rx};
    end
  end

  assign rxs  = sync_q[SYNC_STAGES-1];
  assign tick = (timer_q == LAST_TICK);

  // Next-state logic. Pulses are computed on the transition so they are registered outputs.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    ultimo_d   = ultimo_q;
    right_d    = 1'b0;
    left_d     = 1'b0;
    enter_d    = 1'b0;
    invalido_d = 1'b0;
    erro_d     = 1'b0;

    unique case (state_q)
      StOcioso: begin
        if (!rxs) begin
          state_d = StInicio;
          timer_d = '0;
        end
      end

      StInicio: begin
        // Resample at the middle of the start bit. A high level there means it was a glitch.
        if (timer_q == HALF_TICK) begin
          timer_d = '0;
          if (rxs) begin
            state_d = StOcioso;
          end else begin
            state_d   = StDados;
            bit_idx_d = '0;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      StDados: begin
        if (tick) begin
          timer_d   = '0;
          shift_d   = {rxs, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == 3'd7) begin
`ifdef RX_PARITY_EN
            state_d = StParidade;
`else
            state_d = StParada;
`endif
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

`ifdef RX_PARITY_EN
      StParidade: begin
        if (tick) begin
          timer_d = '0;
          if (^{shift_q, rxs}) begin
            erro_d  = 1'b1;
            state_d = StEspera;
          end else begin
            state_d = StParada;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
`endif

      StParada: begin
        if (tick) begin
          timer_d = '0;
          if (rxs) begin
            // Byte and pulse become visible together during the StDecodifica cycle.
            state_d  = StDecodifica;
            ultimo_d = shift_q;
            case (shift_q)
              CMD_RIGHT: right_d    = 1'b1;
              CMD_LEFT:  left_d     = 1'b1;
              CMD_ENTER: enter_d    = 1'b1;
              default:   invalido_d = 1'b1;
            endcase
          end else begin
            erro_d  = 1'b1;
            state_d = StEspera;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      StDecodifica: begin
        state_d = StOcioso;
      end

      StEspera: begin
        // Wait for a full bit-time of idle so a held break is not read as start bits.
        if (!rxs) begin
          timer_d = '0;
        end else if (tick) begin
          timer_d = '0;
          state_d = StOcioso;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      default: begin
        state_d = StOcioso;
        timer_d = '0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= StOcioso;
      timer_q    <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      ultimo_q   <= '0;
      right_q    <= 1'b0;
      left_q     <= 1'b0;
      enter_q    <= 1'b0;
      invalido_q <= 1'b0;
      erro_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      ultimo_q   <= ultimo_d;
      right_q    <= right_d;
      left_q     <= left_d;
      enter_q    <= enter_d;
      invalido_q <= invalido_d;
      erro_q     <= erro_d;
    end
  end

  assign bus.right_arrow_pressed = right_q;
  assign bus.left_arrow_pressed  = left_q;
  assign bus.enter_pressed       = enter_q;
  assign bus.cmd_invalido        = invalido_q;
  assign bus.erro_quadro         = erro_q;
  assign bus.ultimo_cmd          = ultimo_q;
  assign bus.db_estado           = state_q;

endmodule

// File: tb/tb_receptor_arduino.sv
// Directed bench for receptor_arduino at 16 clocks per bit.
module tb_receptor_arduino;

  localparam int unsigned CLOCK_FREQ  = 50000000;
  localparam int unsigned BAUD        = 3125000;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned C           = 16;
`ifdef RX_PARITY_EN
  localparam int unsigned LAT = SYNC_STAGES + C / 2 + 10 * C + 1;
`else
  localparam int unsigned LAT = SYNC_STAGES + C / 2 + 9 * C + 1;
`endif

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  receptor_arduino_if bus ();

  receptor_arduino #(
    .CLOCK_FREQ  (CLOCK_FREQ),
    .BAUD        (BAUD),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  int unsigned cycle = 0;
  int unsigned fall_cyc = 0;
  int unsigned cnt_right = 0, cnt_left = 0, cnt_enter = 0, cnt_inv = 0, cnt_err = 0;
  int unsigned last_right = 0, last_left = 0, last_enter = 0;
  int unsigned wide = 0, overlap = 0;
  logic [4:0] p, p_prev = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Pulse monitor, sampled 1 ns after each rising edge.
  always begin
    @(posedge clock);
    cycle++;
    #1;
    p = {bus.right_arrow_pressed, bus.left_arrow_pressed, bus.enter_pressed,
         bus.cmd_invalido, bus.erro_quadro};
    if ($countones(p) > 1) overlap++;
    if ((p & p_prev) != 5'b0) wide++;
    p_prev = p;
    if (p[4]) begin cnt_right++; last_right = cycle; end
    if (p[3]) begin cnt_left++;  last_left  = cycle; end
    if (p[2]) begin cnt_enter++; last_enter = cycle; end
    if (p[1]) cnt_inv++;
    if (p[0]) cnt_err++;
  end

  // Called at a falling edge; returns at the falling edge one bit-time later.
  task automatic hold_bit(input logic v);
    bus.rx = v;
    repeat (C) @(negedge clock);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input logic bad_par);
    fall_cyc = cycle;
    hold_bit(1'b0);
    for (int i = 0; i < 8; i++) hold_bit(b[i]);
`ifdef RX_PARITY_EN
    hold_bit((^b) ^ bad_par);
`else
    if (bad_par) $display("note: parity request ignored in 8N1 build");
`endif
    hold_bit(stop_bit);
  endtask

  initial begin
    bus.rx = 1'b1;
    reset  = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_pulses", {27'b0, bus.right_arrow_pressed, bus.left_arrow_pressed,
          bus.enter_pressed, bus.cmd_invalido, bus.erro_quadro}, 32'h0);
    check("reset_ultimo", bus.ultimo_cmd, 32'h00);
    check("reset_estado", bus.db_estado, 32'd0);
    reset = 1'b1;

    repeat (1000) @(negedge clock);
    check("idle_pulses", cnt_right + cnt_left + cnt_enter + cnt_inv + cnt_err, 0);
    check("idle_ultimo", bus.ultimo_cmd, 32'h00);
    check("idle_estado", bus.db_estado, 32'd0);

    // Three commands back to back.
    send_byte(8'h52, 1'b1, 1'b0);
    check("r_count", cnt_right, 1);
    check("r_latency", last_right - fall_cyc, LAT);
    check("r_ultimo", bus.ultimo_cmd, 32'h52);
    send_byte(8'h4C, 1'b1, 1'b0);
    check("l_count", cnt_left, 1);
    check("l_latency", last_left - fall_cyc, LAT);
    check("l_ultimo", bus.ultimo_cmd, 32'h4C);
    send_byte(8'h45, 1'b1, 1'b0);
    check("e_count", cnt_enter, 1);
    check("e_latency", last_enter - fall_cyc, LAT);
    check("e_ultimo", bus.ultimo_cmd, 32'h45);
    check("rle_other", cnt_inv + cnt_err, 0);

    // Unknown command.
    send_byte(8'h41, 1'b1, 1'b0);
    check("inv_count", cnt_inv, 1);
    check("inv_ultimo", bus.ultimo_cmd, 32'h41);
    check("inv_no_cmd", cnt_right + cnt_left + cnt_enter, 3);

    // Framing error followed by a long break.
    send_byte(8'h45, 1'b0, 1'b0);
    check("fe_err", cnt_err, 1);
    check("fe_no_enter", cnt_enter, 1);
    check("fe_ultimo", bus.ultimo_cmd, 32'h41);
    repeat (20 * C) @(negedge clock);
    check("break_espera_a", bus.db_estado, 32'd6);
    repeat (20 * C) @(negedge clock);
    check("break_espera_b", bus.db_estado, 32'd6);
    hold_bit(1'b1);
    hold_bit(1'b1);
    check("break_exit", bus.db_estado, 32'd0);
    send_byte(8'h52, 1'b1, 1'b0);
    check("after_break_r", cnt_right, 2);
    check("after_break_ultimo", bus.ultimo_cmd, 32'h52);

    // Short glitch on the line.
    bus.rx = 1'b0;
    repeat (3) @(negedge clock);
    check("glitch_inicio", bus.db_estado, 32'd1);
    bus.rx = 1'b1;
    repeat (2 * C) @(negedge clock);
    check("glitch_estado", bus.db_estado, 32'd0);
    check("glitch_pulses", cnt_right + cnt_left + cnt_enter + cnt_inv + cnt_err, 6);

    // Reset in the middle of the data bits of 0x52.
    hold_bit(1'b0);
    hold_bit(1'b0);
    hold_bit(1'b1);
    hold_bit(1'b0);
    check("mid_dados", bus.db_estado, 32'd2);
    reset  = 1'b0;
    bus.rx = 1'b1;
    repeat (4) @(negedge clock);
    check("mid_reset_ultimo", bus.ultimo_cmd, 32'h00);
    check("mid_reset_estado", bus.db_estado, 32'd0);
    reset = 1'b1;
    repeat (2 * C) @(negedge clock);
    check("mid_no_right", cnt_right, 2);
    send_byte(8'h4C, 1'b1, 1'b0);
    check("mid_left", cnt_left, 2);
    check("mid_right_still", cnt_right, 2);
    check("mid_ultimo", bus.ultimo_cmd, 32'h4C);

`ifdef RX_PARITY_EN
    send_byte(8'h52, 1'b1, 1'b1);
    repeat (2 * C) @(negedge clock);
    check("par_err", cnt_err, 2);
    check("par_no_right", cnt_right, 2);
    check("par_ultimo", bus.ultimo_cmd, 32'h4C);
    send_byte(8'h45, 1'b1, 1'b0);
    check("par_recover", cnt_enter, 2);
    check("par_latency", last_enter - fall_cyc, LAT);
`endif

    repeat (C) @(negedge clock);
    check("pulse_width", wide, 0);
    check("pulse_overlap", overlap, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
